inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 101 ++++++++++
 tb/tb_inst_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
//   Drives the instruction memory address from the PC register. The memory
//   returns the instruction word combinationally in the same cycle. Each
//   fetch_req moves the stage through a one-cycle FETCH, which latches the
//   word into ir, advances pc and pulses ir_valid. The stage stops
//   permanently when it fetches HALT_WORD; only rst releases it.
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   addra        - word address to instruction memory (equal to pc)
//   douta        - instruction word from memory
//   fetch_req    - request to fetch the next instruction
//   redirect     - load a non-sequential pc (accepted in IDLE or HOLD only)
//   pc_src       - redirect select: 0 = branch (pc + offset), 1 = jump
//   branch_off   - signed word offset; only the low 8 bits matter mod 256
//   jump_target  - jump field; bits [7:0] form the new pc
//   ir, ir_valid - instruction register; one-cycle pulse after each fetch
//   pc, halted   - PC register; high while halted
//   inst_count   - saturating count of fetched instructions
module inst_fetch #(
  parameter logic [7:0]  RESET_PC  = 8'd0,
  parameter logic [31:0] HALT_WORD = 32'hffffffff
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  addra,
  input  logic [31:0] douta,
  input  logic        fetch_req,
  input  logic        redirect,
  input  logic        pc_src,
  input  logic [15:0] branch_off,
  input  logic [25:0] jump_target,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [7:0]  pc,
  output logic        halted,
  output logic [15:0] inst_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_next;

  // Only the low byte of the offset and jump field reaches the 8-bit pc.
  logic unused_bits;
  assign unused_bits = ^{branch_off[15:8], jump_target[25:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HOLD: if (fetch_req) state_next = FETCH;
      FETCH:      state_next = (douta == HALT_WORD) ? HALT : HOLD;
      HALT:       state_next = HALT;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      ir_valid   <= 1'b0;
      inst_count <= '0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          // A redirect in the same cycle as fetch_req lands before the
          // FETCH cycle, so that fetch uses the redirected pc.
          if (redirect) begin
            pc <= pc_src ? jump_target[7:0] : pc + branch_off[7:0];
          end
        end
        FETCH: begin
          ir       <= douta;
          ir_valid <= 1'b1;
          if (inst_count != '1) inst_count <= inst_count + 16'd1;
          // A halt word leaves pc pointing at the halt instruction.
          if (douta != HALT_WORD) pc <= pc + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign addra  = pc;
  assign halted = (state == HALT);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [7:0]  RPC  = 8'd1;
  localparam logic [31:0] HALT = 32'hffffffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addra;
  logic [31:0] douta;
  logic        fetch_req = 1'b0;
  logic        redirect = 1'b0;
  logic        pc_src = 1'b0;
  logic [15:0] branch_off = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] inst_count;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  assign douta = mem[addra];

  inst_fetch #(.RESET_PC(RPC), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .addra(addra), .douta(douta),
    .fetch_req(fetch_req), .redirect(redirect), .pc_src(pc_src),
    .branch_off(branch_off), .jump_target(jump_target),
    .ir(ir), .ir_valid(ir_valid), .pc(pc), .halted(halted),
    .inst_count(inst_count)
  );

  // Reference model: "busy" means a fetch is happening this cycle,
  // "stopped" means a halt word has been fetched.
  bit          m_busy, m_stopped;
  logic [7:0]  m_pc;
  logic [31:0] m_ir;
  bit          m_valid;
  int unsigned m_count;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc", {24'd0, pc}, {24'd0, m_pc});
    chk("addra", {24'd0, addra}, {24'd0, m_pc});
    chk("ir", ir, m_ir);
    chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_stopped});
    chk("inst_count", {16'd0, inst_count}, (m_count > 32'hffff) ? 32'hffff : m_count);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model across
  // the rising edge, then check every output at the next falling edge.
  task automatic step(input bit f, input bit r, input bit src,
                      input logic [15:0] off, input logic [25:0] jt, input bit rs);
    bit          n_busy, n_stopped, n_valid;
    logic [7:0]  n_pc;
    logic [31:0] n_ir, w;
    int unsigned n_count;
    fetch_req = f; redirect = r; pc_src = src;
    branch_off = off; jump_target = jt; rst = rs;
    n_busy = 0; n_stopped = m_stopped; n_valid = 0;
    n_pc = m_pc; n_ir = m_ir; n_count = m_count;
    if (rs) begin
      n_stopped = 0; n_pc = RPC; n_ir = '0; n_count = 0;
    end else if (m_busy) begin
      w = mem[m_pc];
      n_ir = w;
      n_valid = 1;
      n_count = m_count + 1;
      if (w == HALT) n_stopped = 1;
      else n_pc = m_pc + 8'd1;
    end else if (!m_stopped) begin
      if (r) n_pc = src ? jt[7:0] : 8'(m_pc + off[7:0]);
      n_busy = f;
    end
    @(posedge clk);
    m_busy = n_busy; m_stopped = n_stopped; m_valid = n_valid;
    m_pc = n_pc; m_ir = n_ir; m_count = n_count;
    @(negedge clk);
    fetch_req = 0; redirect = 0; rst = 0;
    compare_all();
  endtask

  task automatic idle(); step(0, 0, 0, '0, '0, 0); endtask
  task automatic jump(input logic [7:0] a); step(0, 1, 1, '0, {18'd0, a}, 0); endtask
  task automatic fetch(); step(1, 0, 0, '0, '0, 0); step(0, 0, 0, '0, '0, 0); endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    m_busy = 0; m_stopped = 0; m_valid = 0; m_pc = RPC; m_ir = '0; m_count = 0;
    @(negedge clk);

    step(0, 0, 0, '0, '0, 1);
    chk("reset_pc", {24'd0, addra}, 32'd1);
    chk("reset_ir", ir, 32'h0);
    idle();
    chk("no_fetch_without_req", {24'd0, pc}, 32'd1);

    // First fetch from RESET_PC
    mem[1] = 32'h20010009;
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 0);
    chk("first_ir", ir, 32'h20010009);
    chk("first_pc", {24'd0, pc}, 32'd2);
    chk("first_valid", {31'd0, ir_valid}, 32'd1);
    chk("first_count", {16'd0, inst_count}, 32'd1);
    idle();
    chk("valid_one_cycle", {31'd0, ir_valid}, 32'd0);

    // Branches relative to pc after fetching from address 8
    mem[8] = 32'h1520000b;
    jump(8'd8);
    fetch();
    chk("pc_after_8", {24'd0, pc}, 32'd9);
    step(0, 1, 0, 16'd11, '0, 0);
    chk("branch_fwd", {24'd0, pc}, 32'd20);
    jump(8'd9);
    step(0, 1, 0, 16'hfffb, '0, 0);
    chk("branch_back", {24'd0, pc}, 32'd4);

    // Redirect plus fetch_req in the same cycle
    step(1, 1, 1, '0, 26'h3, 0);
    chk("redirect_fetch_addr", {24'd0, addra}, 32'd3);
    step(1, 1, 1, '0, 26'h40, 0);   // ignored during FETCH
    chk("ignored_in_fetch", {24'd0, pc}, 32'd4);

    // Wrap from 0xff
    jump(8'hff);
    fetch();
    chk("pc_wrap", {24'd0, pc}, 32'd0);

    // Reset during a FETCH cycle
    step(1, 0, 0, '0, '0, 0);
    step(0, 0, 0, '0, '0, 1);
    chk("rst_fetch_pc", {24'd0, pc}, 32'd1);
    chk("rst_fetch_ir", ir, 32'h0);
    chk("rst_fetch_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_fetch_count", {16'd0, inst_count}, 32'd0);

    // Halt at RESET_PC
    mem[1] = HALT;
    fetch();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {24'd0, pc}, 32'd1);
    chk("halt_ir", ir, HALT);
    chk("halt_entry_valid", {31'd0, ir_valid}, 32'd1);
    step(1, 1, 1, '0, 26'h55, 0);
    step(1, 1, 0, 16'd7, '0, 0);
    chk("halt_holds_pc", {24'd0, pc}, 32'd1);
    chk("halt_count", {16'd0, inst_count}, 32'd1);
    step(0, 0, 0, '0, '0, 1);
    chk("halt_released", {31'd0, halted}, 32'd0);

    // Random phase against the model
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           16'($urandom), 26'($urandom), $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
